soc_reset_ctrl: RTL and testbench

- Reset sequencer directly upstream of the soc top; drives the soc's active-low reset_n input.
- Merges four reset sources into one clean, stretched, registered reset for the soc:
  - the board-level power-on reset;
  - a debounced external push-button;
  - a software reset request from the soc;
  - an optional watchdog.
- Records the cause of the last reset and keeps a saturating reset counter for bring-up debug.

---
 rtl/soc_reset_ctrl.sv | 137 +++++++++++++
 tb/tb_soc_reset_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_reset_ctrl.sv
// Reset sequencer: merges POR, a debounced push-button, software and watchdog requests into one
// stretched, registered active-low soc reset. Watchdog is built only with SOC_RESET_CTRL_WDT_EN.
module soc_reset_ctrl #(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WDT_CYCLES      = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ext_rst_req,
  input  logic       sw_rst_req,
  input  logic       wdt_kick,
  output logic       soc_reset_n,
  output logic       busy,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  // One extra code so the debounce count can sit at DEBOUNCE_CYCLES without wrapping.
  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [DebW-1:0]  DebMax   = DebW'(DEBOUNCE_CYCLES);

  typedef enum logic {StHold, StRun} state_e;
  typedef enum logic [1:0] {
    CausePor = 2'b00,
    CauseExt = 2'b01,
    CauseSw  = 2'b10,
    CauseWdt = 2'b11
  } cause_e;

  state_e           state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             soc_reset_n_q;
  logic [1:0]       rst_cause_q;
  logic [7:0]       rst_count_q;
  logic             hold_done;
  logic             wdt_fire;
  logic             any_req;

  // Push-button synchroniser and debounce
  logic            ext_s1_q, ext_s2_q, ext_db_q;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    deb_cnt_d = deb_cnt_q;
    if (!ext_s2_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DebMax) begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_s1_q  <= 1'b0;
      ext_s2_q  <= 1'b0;
      deb_cnt_q <= '0;
      ext_db_q  <= 1'b0;
    end else begin
      ext_s1_q  <= ext_rst_req;
      ext_s2_q  <= ext_s1_q;
      deb_cnt_q <= deb_cnt_d;
      ext_db_q  <= (deb_cnt_d == DebMax);
    end
  end

  assign hold_done = (state_q == StHold) && !ext_db_q && (hold_cnt_q == HoldLast);

`ifdef SOC_RESET_CTRL_WDT_EN
  localparam int unsigned WdtW = $clog2(WDT_CYCLES);
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);

  logic [WdtW-1:0] wdt_cnt_q;

  // A kick on the expiry cycle wins over the timeout.
  assign wdt_fire = (state_q == StRun) && (wdt_cnt_q == WdtLast) && !wdt_kick;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdt_cnt_q <= '0;
    end else if (state_q == StHold) begin
      if (hold_done) wdt_cnt_q <= '0;
    end else if (wdt_kick) begin
      wdt_cnt_q <= '0;
    end else if (wdt_cnt_q != WdtLast) begin
      wdt_cnt_q <= wdt_cnt_q + 1'b1;
    end
  end
`else
  logic unused_wdt;
  assign unused_wdt = wdt_kick ^ (WDT_CYCLES == 0);
  assign wdt_fire   = 1'b0;
`endif

  assign any_req = ext_db_q || sw_rst_req || wdt_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StHold;
      hold_cnt_q    <= '0;
      soc_reset_n_q <= 1'b0;
      rst_cause_q   <= CausePor;
      rst_count_q   <= '0;
    end else begin
      unique case (state_q)
        StHold: begin
          // A held button keeps restarting the stretch.
          if (ext_db_q) begin
            hold_cnt_q <= '0;
          end else if (hold_done) begin
            state_q       <= StRun;
            soc_reset_n_q <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        StRun: begin
          if (any_req) begin
            state_q       <= StHold;
            hold_cnt_q    <= '0;
            soc_reset_n_q <= 1'b0;
            rst_cause_q   <= ext_db_q ? CauseExt : (sw_rst_req ? CauseSw : CauseWdt);
            if (rst_count_q != 8'hff) rst_count_q <= rst_count_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign soc_reset_n = soc_reset_n_q;
  assign busy        = ~soc_reset_n_q;
  assign rst_cause   = rst_cause_q;
  assign rst_count   = rst_count_q;

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// Self-checking bench for soc_reset_ctrl: directed scenarios plus random stimulus against an
// event-level model of the reset rules. Watchdog checks follow SOC_RESET_CTRL_WDT_EN.
module tb_soc_reset_ctrl;

  localparam int unsigned Hold = 16;
  localparam int unsigned Deb  = 4;
  localparam int unsigned Wdt  = 1024;

  logic       clk = 1'b0;
  logic       reset, ext_rst_req, sw_rst_req, wdt_kick;
  logic       soc_reset_n, busy;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;
  logic [11:0] dut_vec;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  soc_reset_ctrl #(
    .HOLD_CYCLES    (Hold),
    .DEBOUNCE_CYCLES(Deb),
    .WDT_CYCLES     (Wdt)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ext_rst_req(ext_rst_req),
    .sw_rst_req (sw_rst_req),
    .wdt_kick   (wdt_kick),
    .soc_reset_n(soc_reset_n),
    .busy       (busy),
    .rst_cause  (rst_cause),
    .rst_count  (rst_count)
  );

  assign dut_vec = {soc_reset_n, busy, rst_cause, rst_count};

  // Reference model: the soc is held in reset until Hold consecutive edges pass with no debounced
  // button; the button counts once its synchronised level has been high for Deb edges in a row;
  // the watchdog barks Wdt edges after RUN entry or the last kick.
  bit         m_hold;
  int         m_quiet;
  logic [1:0] m_cause;
  logic [7:0] m_count;
  bit         m_s1, m_s2, m_db;
  int         m_run;
  longint     m_cyc = 0;
  longint     m_wdt_ref = 0;

  always @(posedge clk) begin
    bit ext_f, sw_f, wdt_f;
    m_cyc++;
    if (reset) begin
      m_hold  = 1; m_quiet = 0; m_cause = 2'b00; m_count = 8'd0;
      m_s1 = 0; m_s2 = 0; m_run = 0; m_db = 0;
    end else begin
      if (m_hold) begin
        m_quiet = m_db ? 0 : m_quiet + 1;
        if (m_quiet == Hold) begin
          m_hold    = 0;
          m_wdt_ref = m_cyc;
        end
      end else begin
        ext_f = m_db;
        sw_f  = sw_rst_req;
        wdt_f = 0;
`ifdef SOC_RESET_CTRL_WDT_EN
        wdt_f = (m_cyc - m_wdt_ref == Wdt) && !wdt_kick;
        if (wdt_kick) m_wdt_ref = m_cyc;
`endif
        if (ext_f || sw_f || wdt_f) begin
          m_hold  = 1;
          m_quiet = 0;
          m_cause = ext_f ? 2'b01 : (sw_f ? 2'b10 : 2'b11);
          if (m_count < 8'd255) m_count = m_count + 8'd1;
        end
      end
      m_run = m_s2 ? ((m_run < Deb) ? m_run + 1 : Deb) : 0;
      m_db  = (m_run == Deb);
      m_s2  = m_s1;
      m_s1  = ext_rst_req;
    end
  end

  function automatic logic [11:0] exp_vec();
    return {~m_hold, m_hold, m_cause, m_count};
  endfunction

  task automatic wait_run(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (soc_reset_n === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (soc_reset_n === 1'b1) ok = 1;
  endtask

  task automatic test_reset();
    logic rn;
    reset = 1; ext_rst_req = 0; sw_rst_req = 0; wdt_kick = 0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dut_vec !== 12'h400) begin
      n_err++;
      $display("FAIL por_asserted: got %h want %h", dut_vec, 12'h400);
    end
    reset = 0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      rn = (i >= 16);
      n_vec++;
      if (dut_vec !== {rn, ~rn, 2'b00, 8'd0}) begin
        n_err++;
        $display("FAIL por_stretch[%0d]: got %h want %h", i, dut_vec, {rn, ~rn, 2'b00, 8'd0});
      end
    end
  endtask

  task automatic test_sw_reset();
    logic [7:0] base;
    logic       rn;
    base = m_count;
    sw_rst_req = 1;
    for (int i = 0; i <= 17; i++) begin
      @(negedge clk);
      sw_rst_req = 0;
      rn = (i >= 16);
      n_vec++;
      if (dut_vec !== {rn, ~rn, 2'b10, base + 8'd1}) begin
        n_err++;
        $display("FAIL sw_reset[%0d]: got %h want %h", i, dut_vec, {rn, ~rn, 2'b10, base + 8'd1});
      end
    end
  endtask

  task automatic test_debounce();
    logic [7:0] base;
    logic [1:0] cause0;
    logic       rn;
    base   = m_count;
    cause0 = m_cause;
    // Glitch shorter than the debounce window
    ext_rst_req = 1;
    repeat (3) @(negedge clk);
    ext_rst_req = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_vec++;
      if (dut_vec !== {2'b10, cause0, base}) begin
        n_err++;
        $display("FAIL glitch[%0d]: got %h want %h", i, dut_vec, {2'b10, cause0, base});
      end
    end
    // Held for 20 edges: falls on edge 7, released stretch ends on edge 39
    ext_rst_req = 1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      rn = !(i >= 7 && i <= 38);
      n_vec++;
      if (dut_vec !== {rn, ~rn, (i >= 7) ? 2'b01 : cause0, (i >= 7) ? base + 8'd1 : base}) begin
        n_err++;
        $display("FAIL button_hold[%0d]: got %h want %h", i, dut_vec,
                 {rn, ~rn, (i >= 7) ? 2'b01 : cause0, (i >= 7) ? base + 8'd1 : base});
      end
      if (i == 20) ext_rst_req = 0;
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] base;
    bit         ok;
    base = m_count;
    ext_rst_req = 1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      sw_rst_req = (i == 6);
    end
    n_vec++;
    if (dut_vec !== {2'b01, 2'b01, base + 8'd1}) begin
      n_err++;
      $display("FAIL simultaneous: got %h want %h", dut_vec, {2'b01, 2'b01, base + 8'd1});
    end
    repeat (4) @(negedge clk);
    ext_rst_req = 0;
    wait_run(60, ok);
    n_vec++;
    if (!ok || dut_vec !== {2'b10, 2'b01, base + 8'd1}) begin
      n_err++;
      $display("FAIL simultaneous_after: got %h want %h ok=%0d", dut_vec,
               {2'b10, 2'b01, base + 8'd1}, ok);
    end
  endtask

  task automatic test_watchdog();
`ifdef SOC_RESET_CTRL_WDT_EN
    bit   ok;
    logic rn;
    // Last kick lands on edge 1000; expiry edge is 1000 + Wdt
    for (int c = 0; c <= 2030; c++) begin
      wdt_kick = (c % 500 == 0) && (c <= 1000);
      @(negedge clk);
      rn = !(c >= 1000 + Wdt);
      if (c % 100 == 0 || c >= 1000 + Wdt - 2) begin
        n_vec++;
        if (soc_reset_n !== rn || (c >= 1000 + Wdt && rst_cause !== 2'b11)) begin
          n_err++;
          $display("FAIL watchdog[%0d]: soc_reset_n=%b want %b cause=%b", c, soc_reset_n, rn,
                   rst_cause);
        end
      end
    end
    wdt_kick = 0;
    wait_run(40, ok);
`else
    bit bad;
    bad = 0;
    wdt_kick = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (soc_reset_n !== 1'b1 || rst_cause === 2'b11) bad = 1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL no_watchdog: soc_reset_n=%b cause=%b want 1 and cause!=11", soc_reset_n,
               rst_cause);
    end
`endif
  endtask

  task automatic test_random();
    int ext_left;
    int rst_left;
    ext_left = 0;
    rst_left = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", c, dut_vec, exp_vec());
      end
      if (rst_left > 0) rst_left--;
      else if ($urandom_range(399, 0) == 0) rst_left = $urandom_range(3, 1);
      reset = (rst_left > 0);
      if (ext_left > 0) ext_left--;
      else if ($urandom_range(59, 0) == 0) ext_left = $urandom_range(30, 1);
      ext_rst_req = (ext_left > 0);
      sw_rst_req  = ($urandom_range(29, 0) == 0);
      wdt_kick    = ($urandom_range(299, 0) == 0);
    end
    reset = 0; ext_rst_req = 0; sw_rst_req = 0; wdt_kick = 0;
  endtask

  task automatic test_saturation();
    bit ok;
    for (int k = 0; k < 300; k++) begin
      wait_run(100, ok);
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL saturation_wait[%0d]: soc_reset_n=%b want 1", k, soc_reset_n);
        break;
      end
      sw_rst_req = 1;
      @(negedge clk);
      sw_rst_req = 0;
    end
    wait_run(100, ok);
    n_vec++;
    if (!ok || dut_vec !== {2'b10, 2'b10, 8'd255}) begin
      n_err++;
      $display("FAIL saturation: got %h want %h", dut_vec, {2'b10, 2'b10, 8'd255});
    end
  endtask

  task automatic test_abort();
    logic rn;
    sw_rst_req = 1;
    @(negedge clk);
    sw_rst_req = 0;
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    n_vec++;
    if (dut_vec !== 12'h400) begin
      n_err++;
      $display("FAIL abort_reset: got %h want %h", dut_vec, 12'h400);
    end
    reset = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      rn = (i >= 16);
      if (i >= 14) begin
        n_vec++;
        if (dut_vec !== {rn, ~rn, 2'b00, 8'd0}) begin
          n_err++;
          $display("FAIL abort_restart[%0d]: got %h want %h", i, dut_vec,
                   {rn, ~rn, 2'b00, 8'd0});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sw_reset();
    test_debounce();
    test_simultaneous();
    test_watchdog();
    test_random();
    test_saturation();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

endmodule
